// File: rtl/spi_read_master_if.sv
// spi_read_master_if: request/response handshake between fetch logic and the SPI read master
interface spi_read_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/spi_read_master.sv
// spi_read_master: SPI mode-0 master fetching one byte per request via READ + 16-bit address
module spi_read_master #(
    parameter int         DIV = 2,
    parameter logic [7:0] CMD = 8'h03
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_read_master_if.slave   bus,
    output logic               busy,
    output logic               spi_cs_n,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   sh_q, sh_d;
    logic [7:0]    rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic          cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d, rsp_valid_q, rsp_valid_d;
    logic          tick;
    assign tick = div_q == DMAX;
    always_comb begin
        state_d     = state_q;
        div_d       = (state_q inside {SETUP, SHIFT, HOLD}) && !tick ? div_q + 1'b1 : '0;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = SETUP;
                cs_n_d  = 1'b0;
                sh_d    = {CMD, bus.req_addr, 8'h00};
                mosi_d  = CMD[7];
                cnt_d   = 5'd31;
            end
            SETUP: if (tick) begin
                state_d = SHIFT;
                sck_d   = 1'b1;
            end
            SHIFT: if (tick && !sck_q) begin
                sck_d = 1'b1;
                // cnt_q tracks the frame bit on MOSI; the last 8 rises carry the data byte
                if (cnt_q < 5'd8) rx_d = {rx_q[6:0], spi_miso};
            end else if (tick) begin
                sck_d = 1'b0;
                if (cnt_q == 5'd0) begin
                    mosi_d  = 1'b0;
                    state_d = HOLD;
                end else begin
                    cnt_d  = cnt_q - 5'd1;
                    sh_d   = sh_q << 1;
                    mosi_d = sh_q[30];
                end
            end
            HOLD: if (tick) begin
                state_d     = RESP;
                cs_n_d      = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_data_d  = rx_q;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    assign bus.req_ready = rst_n && state_q == IDLE;
    assign busy          = rst_n && state_q != IDLE;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;
endmodule

// File: tb/tb_spi_read_master.sv
// tb_spi_read_master: checks a DIV=2 and a DIV=1 master against a frame-timing model and SPI RAM slaves
module tb_spi_read_master;
    logic        clk = 1'b0;
    logic [1:0]  rst_n, req_valid, rsp_ready;
    logic [15:0] req_addr [2];
    logic [7:0]  mem [2][256];
    wire  [1:0]  req_ready, rsp_valid, busy, cs_n, sck, mosi, miso;
    wire  [7:0]  rsp_data [2];
    wire  [31:0] fr_w [2];
    wire  [5:0]  nr_w [2], last_w [2];
    int          n_cmp = 0, n_bad = 0, ecnt = 0;
    int          ph [2], e0 [2];
    logic [15:0] ma [2];
    logic [7:0]  md [2];
    initial forever #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : d
        localparam int DV = (g == 0) ? 2 : 1;
        spi_read_master_if bus ();
        logic [5:0]  nr = '0, last = '0;
        logic [31:0] fr = '0;
        logic [7:0]  rb = '0;
        logic        mi = 1'b0;
        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_data[g]   = bus.rsp_data;
        assign miso[g]       = mi;
        assign fr_w[g]       = fr;
        assign nr_w[g]       = nr;
        assign last_w[g]     = last;
        spi_read_master #(.DIV(DV), .CMD(8'h03)) dut (
            .clk(clk), .rst_n(rst_n[g]), .bus(bus), .busy(busy[g]),
            .spi_cs_n(cs_n[g]), .spi_sck(sck[g]), .spi_mosi(mosi[g]), .spi_miso(miso[g])
        );
        // SPI RAM slave: capture MOSI on rises, drive data bits on falls after the 24th rise
        always @(posedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                last <= nr;
                nr   <= '0;
            end else begin
                fr <= {fr[30:0], mosi[g]};
                nr <= nr + 6'd1;
            end
        end
        always @(negedge sck[g]) begin
            if (!cs_n[g] && nr == 6'd24) begin
                mi <= mem[g][fr[7:0]][7];
                rb <= mem[g][fr[7:0]] << 1;
            end else if (!cs_n[g] && nr > 6'd24 && nr < 6'd32) begin
                mi <= rb[7];
                rb <= rb << 1;
            end
        end
    end
    function automatic int dv(int i);
        return (i == 0) ? 2 : 1;
    endfunction
    task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at edge %0d: got %0h, want %0h", nm, i, ecnt, act, exp);
        end
    endtask
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic issue(int i, logic [15:0] a, output int e);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        for (int k = 0; k < 300 && !req_ready[i]; k++) step(1);
        check("accept_wait", i, req_ready[i], 1);
        step(1);
        e = ecnt;
        req_valid[i] = 1'b0;
    endtask
    task automatic wait_rsp(int i, output int e);
        for (int k = 0; k < 1000 && !rsp_valid[i]; k++) step(1);
        check("rsp_wait", i, rsp_valid[i], 1);
        e = ecnt;
    endtask
    initial begin
        int e, r, gap;
        rst_n = 2'b00; req_valid = 2'b00; rsp_ready = 2'b00;
        req_addr[0] = '0; req_addr[1] = '0;
        ph[0] = 0; ph[1] = 0; e0[0] = 0; e0[1] = 0;
        ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
        for (int k = 0; k < 256; k++) begin
            mem[0][k] = 8'h00;
            mem[1][k] = 8'h00;
        end
        mem[0][8'h5A] = 8'hC3; mem[0][8'hFF] = 8'hA5; mem[0][8'h01] = 8'h3C;
        mem[0][8'h10] = 8'h81; mem[1][8'h00] = 8'h7E;
        fork
            // model: idle -> frame (65*DIV cycles from accept) -> response until rsp_ready
            forever begin
                @(posedge clk);
                ecnt++;
                for (int i = 0; i < 2; i++) begin
                    if (!rst_n[i]) begin
                        ph[i] = 0;
                        md[i] = '0;
                    end else if (ph[i] == 0 && req_valid[i]) begin
                        ph[i] = 1; e0[i] = ecnt; ma[i] = req_addr[i];
                    end else if (ph[i] == 1 && ecnt - e0[i] == 65 * dv(i)) begin
                        ph[i] = 2; md[i] = mem[i][ma[i][7:0]];
                    end else if (ph[i] == 2 && rsp_ready[i]) ph[i] = 0;
                end
            end
            forever begin
                @(negedge clk);
                if (ecnt > 0) for (int i = 0; i < 2; i++) begin
                    int t, v;
                    logic [31:0] f;
                    logic es, em;
                    v = dv(i); t = ecnt - e0[i]; f = {8'h03, ma[i], 8'h00};
                    es = 1'b0; em = 1'b0;
                    if (ph[i] == 1 && t < 64 * v) begin
                        em = f[31 - t / (2 * v)];
                        es = t >= v && ((t - v) / v) % 2 == 0;
                    end
                    check("cs_n", i, cs_n[i], ph[i] != 1);
                    check("sck", i, sck[i], es);
                    check("mosi", i, mosi[i], em);
                    check("busy", i, busy[i], rst_n[i] && ph[i] != 0);
                    check("req_ready", i, req_ready[i], rst_n[i] && ph[i] == 0);
                    check("rsp_valid", i, rsp_valid[i], ph[i] == 2);
                    check("rsp_data", i, rsp_data[i], md[i]);
                end
            end
        join_none
        step(3);
        check("rst_cs_n", 0, cs_n[0], 1);
        check("rst_sck", 0, sck[0], 0);
        check("rst_mosi", 0, mosi[0], 0);
        check("rst_rsp_valid", 0, rsp_valid[0], 0);
        check("rst_busy", 0, busy[0], 0);
        check("rst_req_ready", 0, req_ready[0], 0);
        rst_n = 2'b11;
        #1;
        check("rel_req_ready", 0, req_ready[0], 1);
        check("rel_req_ready", 1, req_ready[1], 1);
        issue(0, 16'h005A, e);
        wait_rsp(0, r);
        check("latency_div2", 0, r - e, 130);
        check("data_c3", 0, rsp_data[0], 8'hC3);
        check("frame_bits", 0, fr_w[0], 32'h03005A00);
        check("rise_count", 0, last_w[0], 32);
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h00FF;
        step(20);
        check("bp_rsp_valid", 0, rsp_valid[0], 1);
        check("bp_rsp_data", 0, rsp_data[0], 8'hC3);
        check("bp_cs_n", 0, cs_n[0], 1);
        check("bp_sck", 0, sck[0], 0);
        check("bp_req_ready", 0, req_ready[0], 0);
        rsp_ready[0] = 1'b1;
        step(1);
        check("hs_rsp_valid", 0, rsp_valid[0], 0);
        check("hs_req_ready", 0, req_ready[0], 1);
        step(1);
        check("bp_accept_busy", 0, busy[0], 1);
        check("bp_accept_cs_n", 0, cs_n[0], 0);
        req_addr[0] = 16'h0001;
        wait_rsp(0, r);
        check("data_a5", 0, rsp_data[0], 8'hA5);
        gap = 0;
        while (cs_n[0] && gap < 20) begin
            gap++;
            step(1);
        end
        check("cs_gap", 0, gap, 2);
        req_valid[0] = 1'b0;
        wait_rsp(0, r);
        check("data_3c", 0, rsp_data[0], 8'h3C);
        step(1);
        issue(0, 16'h005A, e);
        for (int k = 0; k < 200 && nr_w[0] != 6'd10; k++) step(1);
        check("tenth_rise", 0, nr_w[0], 10);
        rst_n[0] = 1'b0;
        step(1);
        check("abort_cs_n", 0, cs_n[0], 1);
        check("abort_sck", 0, sck[0], 0);
        check("abort_rsp_valid", 0, rsp_valid[0], 0);
        check("abort_busy", 0, busy[0], 0);
        check("abort_rises", 0, last_w[0], 10);
        rst_n[0] = 1'b1;
        issue(0, 16'h0010, e);
        wait_rsp(0, r);
        check("data_81", 0, rsp_data[0], 8'h81);
        step(2);
        rsp_ready[1] = 1'b1;
        issue(1, 16'h0000, e);
        wait_rsp(1, r);
        check("latency_div1", 1, r - e, 65);
        check("data_7e", 1, rsp_data[1], 8'h7E);
        check("frame_bits", 1, fr_w[1], 32'h03000000);
        check("rise_count", 1, last_w[1], 32);
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_read_master.md
Name: spi_read_master

Overview:
- Clocked SPI mode-0 master that fetches one byte from an external SPI RAM using the READ command (0x03) with a 16-bit address.
- Sits between the CPU fetch/load logic and the SPI RAM. It is the host-side driver of spi_ram_model in simulation and of real RAM on silicon.
- Takes a request over a valid/ready handshake, runs one 32-bit SPI frame, and returns the byte over a valid/ready response handshake.

Parameters:
- DIV, 2, SCK half-period in clk cycles; legal range ≥1. SCK frequency = clk/(2*DIV).
- CMD, 8'h03, command byte sent first in every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE and not in reset; accept = req_valid & req_ready at a clk edge.
- req_addr  input  16  byte address; sampled only on the accept edge.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes data.
- rsp_data  output  8  byte read.
- busy  output  1  high in every state except IDLE.
- spi_cs_n  output  1  chip select, active low, registered.
- spi_sck  output  1  serial clock, idle low, registered.
- spi_mosi  output  1  master out, registered.
- spi_miso  input  1  slave out.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_data=0. While rst_n is low, req_ready=0 and busy=0.
- Frame shift register: {CMD, req_addr[15:0], 8'h00}, sent MSB first, 32 bits.
- States: IDLE, SETUP, SHIFT, HOLD, RESP.
- IDLE -> SETUP on the accept edge E0.
  - At E0: spi_cs_n<=0, spi_mosi<=frame bit 31, shift register and addr latched, bit counter=31, divider cleared.
- SETUP: lasts DIV cycles with SCK low. Then go to SHIFT.
- SHIFT, rise edges: SCK rise k (k=0..31) occurs at edge E0+DIV+2k*DIV.
  - On a rise edge: spi_sck<=1. If k≥24, spi_miso as seen before that edge is shifted into the receive register, MSB first.
- SHIFT, fall edges: SCK falls DIV cycles after each rise.
  - On a fall edge: spi_sck<=0 and spi_mosi<=next frame bit. The slave changes MISO on this same falling edge.
  - After fall 31 (edge E0+64*DIV): spi_mosi<=0, go to HOLD.
- HOLD: DIV cycles with SCK low and spi_cs_n low. At edge E0+65*DIV: spi_cs_n<=1, rsp_valid<=1, rsp_data<=received byte, go to RESP.
- RESP: rsp_valid and rsp_data held stable until an edge with rsp_ready=1. On that edge rsp_valid<=0 and state goes to IDLE.
  - rsp_ready already high when rsp_valid rises: handshake completes on the next edge (RESP lasts 1 cycle).
- Inter-frame gap: req_ready is low in RESP, so a request present during a response handshake is accepted no earlier than the following edge. spi_cs_n is therefore high for ≥2 cycles between frames, which guarantees the slave sees the cs_n rising edge.
- Exactly 32 SCK rises per frame. SCK never toggles while spi_cs_n is high.
- req_valid while busy: ignored. No queueing.
- Divider counter width: enough bits for DIV-1. It wraps to 0 at every phase change.
- Reset mid-frame: on the next edge everything returns to reset values (spi_cs_n=1, spi_sck=0). No rsp_valid pulse. The partial byte is discarded.
- No X propagation: rsp_data only updates at HOLD->RESP.

Test Plan:
- Reset: hold rst_n low 3 cycles, then release -> during reset cs_n=1, sck=0, mosi=0, rsp_valid=0, busy=0, req_ready=0; req_ready=1 in the first cycle after release.
- Single read, DIV=2, spi_ram_model mem[0x5A]=8'hC3, req_addr=16'h005A -> MOSI sampled on SCK rises = 03,00,5A,00; 32 rises; rsp_valid at E0+130; rsp_data=8'hC3.
- Backpressure: rsp_ready low for 20 cycles after rsp_valid -> rsp_valid and rsp_data=C3 held, cs_n=1, sck=0, a pending req_valid not accepted; the request is accepted 2 edges after rsp_ready rises.
- Back-to-back: mem[0xFF]=8'hA5, mem[0x01]=8'h3C, requests 0x00FF then 0x0001, rsp_ready tied high -> responses A5 then 3C; cs_n high ≥2 cycles between frames.
- Reset mid-frame: assert rst_n after the 10th SCK rise -> next edge cs_n=1, sck=0, no rsp_valid. A following request to 0x0010 with mem[0x10]=8'h81 returns 81.
- DIV=1 build: request to 0x0000 with mem[0]=8'h7E -> SCK = clk/2, rsp_valid at E0+65, rsp_data=7E.
